// File: rtl/packed_word_serializer.sv
// Packed word serializer: loads a WIDTH-bit word and emits it one bit per beat, MSB- or LSB-first.
// Optional even-parity trailer beat when SERIAL_PARITY_EN is defined.
module packed_word_serializer #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             is_final;

    // Final index depends on walk direction; the index never wraps past it.
    always_comb begin
        is_final = dir_q ? (idx_q == '0) : (idx_q == LastIdx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            word_q  <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    word_d  = in_data;
                    dir_d   = in_msb_first;
                    idx_d   = in_msb_first ? LastIdx : '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (out_ready) begin
                    if (is_final) begin
`ifdef SERIAL_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StIdle;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d = dir_q ? idx_q - 1'b1 : idx_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_PARITY_EN
            StParity: begin
                if (out_ready) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = done_q;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
            end
            StShift: begin
                out_valid = 1'b1;
                out_bit   = word_q[idx_q];
                out_idx   = idx_q;
                busy      = 1'b1;
`ifdef SERIAL_PARITY_EN
                out_last  = 1'b0;
`else
                out_last  = is_final;
`endif
            end
`ifdef SERIAL_PARITY_EN
            StParity: begin
                out_valid = 1'b1;
                out_bit   = ^word_q;
                out_last  = 1'b1;
                busy      = 1'b1;
            end
`endif
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_packed_word_serializer.sv
// Directed, table-driven bench for packed_word_serializer (WIDTH=16).
// Expected beat streams are hand-written with beat k stored in bit [15-k].
module tb_packed_word_serializer;

`ifdef SERIAL_PARITY_EN
    localparam bit Par = 1'b1;
`else
    localparam bit Par = 1'b0;
`endif
    localparam int NBeats = 16 + (Par ? 1 : 0);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_msb_first = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_bit;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    packed_word_serializer #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_msb_first (in_msb_first),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bit      (out_bit),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        logic [15:0] data;
        bit          msb;
        logic [15:0] stream;
        bit          par;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input bit exp_done);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " out_bit"}, 32'(out_bit), 32'd0);
        check({tag, " out_idx"}, 32'(out_idx), 32'd0);
        check({tag, " out_last"}, 32'(out_last), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'(exp_done));
    endtask

    task automatic check_beat(input string tag, input bit eb, input int ei, input bit el);
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " out_bit"}, 32'(out_bit), 32'(eb));
        check({tag, " out_idx"}, 32'(out_idx), 32'(ei));
        check({tag, " out_last"}, 32'(out_last), 32'(el));
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " in_ready"}, 32'(in_ready), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
    endtask

    task automatic do_load(input logic [15:0] data, input bit msb);
        check("load in_ready", 32'(in_ready), 32'd1);
        in_valid     = 1'b1;
        in_data      = data;
        in_msb_first = msb;
        step();
        in_valid     = 1'b0;
    endtask

    // Walks every beat of one word, optionally stalling before beat stall_k; ends in the done cycle.
    task automatic run_beats(input logic [15:0] stream, input bit msb, input bit par,
                             input int stall_k, input int stall_n);
        bit eb;
        int ei;
        bit el;
        for (int k = 0; k < NBeats; k++) begin
            if (k < 16) begin
                eb = stream[15-k];
                ei = msb ? 15 - k : k;
                el = (k == 15) && !Par;
            end else begin
                eb = par;
                ei = 0;
                el = 1'b1;
            end
            if (k == stall_k) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check_beat("stall", eb, ei, el);
                    step();
                end
                out_ready = 1'b1;
            end
            check_beat("beat", eb, ei, el);
            step();
        end
        check_idle("done cycle", 1'b1);
    endtask

    initial begin
        vecs[0] = '{data: 16'h10FA, msb: 1'b1, stream: 16'h10FA, par: 1'b1};
        vecs[1] = '{data: 16'h10FA, msb: 1'b0, stream: 16'h5F08, par: 1'b1};
        vecs[2] = '{data: 16'h0003, msb: 1'b1, stream: 16'h0003, par: 1'b0};
        vecs[3] = '{data: 16'h0003, msb: 1'b0, stream: 16'hC000, par: 1'b0};
        vecs[4] = '{data: 16'h8001, msb: 1'b0, stream: 16'h8001, par: 1'b0};
        vecs[5] = '{data: 16'hFFFF, msb: 1'b1, stream: 16'hFFFF, par: 1'b0};

        rst_n = 1'b0;
        step();
        step();
        check_idle("reset", 1'b0);
        rst_n = 1'b1;
        step();
        check_idle("post reset", 1'b0);

        for (int v = 0; v < 6; v++) begin
            do_load(vecs[v].data, vecs[v].msb);
            run_beats(vecs[v].stream, vecs[v].msb, vecs[v].par, -1, 0);
            step();
            check_idle("after done", 1'b0);
        end

        // Backpressure on idx12 of an MSB-first word.
        do_load(16'h10FA, 1'b1);
        run_beats(16'h10FA, 1'b1, 1'b1, 3, 3);
        step();
        check_idle("bp after done", 1'b0);

        // Reset after five transferred beats; no done pulse may follow.
        do_load(16'h10FA, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check_beat("pre-reset", vecs[0].stream[15-k], 15 - k, 1'b0);
            step();
        end
        rst_n = 1'b0;
        step();
        check_idle("mid reset", 1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_idle("after reset", 1'b0);
        end

        // Back-to-back: second word held during word 1, accepted in the done cycle.
        do_load(16'h10FA, 1'b1);
        in_valid     = 1'b1;
        in_data      = 16'hFFFF;
        in_msb_first = 1'b1;
        run_beats(16'h10FA, 1'b1, 1'b1, -1, 0);
        step();
        in_valid = 1'b0;
        run_beats(16'hFFFF, 1'b1, 1'b0, -1, 0);
        step();
        check_idle("b2b end", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
